// File: rtl/sample_responder_pkg.sv
// rtl/sample_responder_pkg.sv - shared handshake state encoding and default sizes
package sample_responder_pkg;

  localparam int DEF_DDWIDTH = 32;
  localparam int DEF_DEPTH   = 8;

  typedef enum logic {
    ST_IDLE  = 1'b0,
    ST_ACKED = 1'b1
  } hs_state_t;

endpackage

// File: rtl/sample_fifo.sv
// rtl/sample_fifo.sv - show-ahead pointer FIFO used for both sample channels
module sample_fifo #(
  parameter int DDWIDTH = 32,
  parameter int AWIDTH  = 3
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               push,
  input  logic [0:DDWIDTH-1] push_data,
  input  logic               pop,
  output logic [0:DDWIDTH-1] head,
  output logic               full,
  output logic               empty,
  output logic [0:AWIDTH]    level
);

  localparam int DEPTH = 1 << AWIDTH;

  logic [0:DDWIDTH-1] mem [DEPTH];
  logic [AWIDTH:0]    wr_ptr;
  logic [AWIDTH:0]    rd_ptr;
  logic               do_push;
  logic               do_pop;

  // Extra pointer bit distinguishes full from empty when the indices match.
  assign level   = wr_ptr - rd_ptr;
  assign empty   = (wr_ptr == rd_ptr);
  assign full    = (wr_ptr[AWIDTH] != rd_ptr[AWIDTH]) &&
                   (wr_ptr[AWIDTH-1:0] == rd_ptr[AWIDTH-1:0]);
  assign do_push = push && !full;
  assign do_pop  = pop && !empty;
  assign head    = mem[rd_ptr[AWIDTH-1:0]];

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      for (int i = 0; i < DEPTH; i++) mem[i] <= '0;
    end else begin
      if (do_push) begin
        mem[wr_ptr[AWIDTH-1:0]] <= push_data;
        wr_ptr <= wr_ptr + 1'b1;
      end
      if (do_pop) rd_ptr <= rd_ptr + 1'b1;
    end
  end

endmodule

// File: rtl/sample_responder.sv
// rtl/sample_responder.sv - four-phase req/ack sample responder; SAMPLE_RESPONDER_STATS_EN adds counters
module sample_responder
  import sample_responder_pkg::*;
#(
  parameter int DDWIDTH = DEF_DDWIDTH,
  parameter int DEPTH   = DEF_DEPTH,
  parameter int AWIDTH  = $clog2(DEPTH)
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               src_req,
  output logic               src_ack,
  output logic [0:DDWIDTH-1] src_data,
  input  logic               snk_req,
  output logic               snk_ack,
  input  logic [0:DDWIDTH-1] snk_data,
  input  logic               host_wr_en,
  input  logic [0:DDWIDTH-1] host_wr_data,
  output logic               host_full,
  input  logic               host_rd_en,
  output logic [0:DDWIDTH-1] host_rd_data,
  output logic               host_empty,
  output logic [0:AWIDTH]    src_level,
  output logic [0:AWIDTH]    snk_level
`ifdef SAMPLE_RESPONDER_STATS_EN
  ,
  output logic [31:0]        src_xfers,
  output logic [31:0]        snk_xfers,
  output logic [31:0]        stall_cycles
`endif
);

  hs_state_t          src_state, src_state_nxt;
  hs_state_t          snk_state, snk_state_nxt;
  logic               src_pop;
  logic               snk_push;
  logic               src_empty;
  logic               snk_full;
  logic [0:DDWIDTH-1] src_head;

  sample_fifo #(.DDWIDTH(DDWIDTH), .AWIDTH(AWIDTH)) u_src_fifo (
    .clk       (clk),
    .rst       (rst),
    .push      (host_wr_en),
    .push_data (host_wr_data),
    .pop       (src_pop),
    .head      (src_head),
    .full      (host_full),
    .empty     (src_empty),
    .level     (src_level)
  );

  sample_fifo #(.DDWIDTH(DDWIDTH), .AWIDTH(AWIDTH)) u_snk_fifo (
    .clk       (clk),
    .rst       (rst),
    .push      (snk_push),
    .push_data (snk_data),
    .pop       (host_rd_en),
    .head      (host_rd_data),
    .full      (snk_full),
    .empty     (host_empty),
    .level     (snk_level)
  );

  // Acks are pure state decodes so an async reset drops them without a clock edge.
  assign src_ack = (src_state == ST_ACKED);
  assign snk_ack = (snk_state == ST_ACKED);

  always_comb begin
    src_state_nxt = src_state;
    src_pop       = 1'b0;
    case (src_state)
      ST_IDLE: begin
        if (src_req && !src_empty) begin
          src_pop       = 1'b1;
          src_state_nxt = ST_ACKED;
        end
      end
      ST_ACKED: if (!src_req) src_state_nxt = ST_IDLE;
      default:  src_state_nxt = ST_IDLE;
    endcase
  end

  always_comb begin
    snk_state_nxt = snk_state;
    snk_push      = 1'b0;
    case (snk_state)
      ST_IDLE: begin
        if (snk_req && !snk_full) begin
          snk_push      = 1'b1;
          snk_state_nxt = ST_ACKED;
        end
      end
      ST_ACKED: if (!snk_req) snk_state_nxt = ST_IDLE;
      default:  snk_state_nxt = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      src_state <= ST_IDLE;
      snk_state <= ST_IDLE;
      src_data  <= '0;
    end else begin
      src_state <= src_state_nxt;
      snk_state <= snk_state_nxt;
      if (src_pop) src_data <= src_head;
    end
  end

`ifdef SAMPLE_RESPONDER_STATS_EN
  logic stall;

  // One count per cycle even if both channels are blocked together.
  assign stall = (src_state == ST_IDLE && src_req && src_empty) ||
                 (snk_state == ST_IDLE && snk_req && snk_full);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      src_xfers    <= '0;
      snk_xfers    <= '0;
      stall_cycles <= '0;
    end else begin
      if (src_pop)  src_xfers    <= src_xfers + 32'd1;
      if (snk_push) snk_xfers    <= snk_xfers + 32'd1;
      if (stall)    stall_cycles <= stall_cycles + 32'd1;
    end
  end
`endif

endmodule

// File: tb/tb_sample_responder.sv
// tb/tb_sample_responder.sv - self-checking bench for sample_responder
module tb_sample_responder;

  localparam int DW    = 32;
  localparam int DEPTH = 8;
  localparam int AW    = 3;

  logic          clk = 1'b0;
  logic          rst;
  logic          src_req, snk_req, host_wr_en, host_rd_en;
  logic [0:DW-1] snk_data, host_wr_data;
  logic          src_ack, snk_ack, host_full, host_empty;
  logic [0:DW-1] src_data, host_rd_data;
  logic [0:AW]   src_level, snk_level;
`ifdef SAMPLE_RESPONDER_STATS_EN
  logic [31:0]   src_xfers, snk_xfers, stall_cycles;
`endif

  int checks = 0;
  int errors = 0;
  logic [0:DW-1] q_src[$];
  logic [0:DW-1] q_snk[$];

  always #5 clk = ~clk;

  sample_responder #(.DDWIDTH(DW), .DEPTH(DEPTH), .AWIDTH(AW)) dut (
    .clk          (clk),
    .rst          (rst),
    .src_req      (src_req),
    .src_ack      (src_ack),
    .src_data     (src_data),
    .snk_req      (snk_req),
    .snk_ack      (snk_ack),
    .snk_data     (snk_data),
    .host_wr_en   (host_wr_en),
    .host_wr_data (host_wr_data),
    .host_full    (host_full),
    .host_rd_en   (host_rd_en),
    .host_rd_data (host_rd_data),
    .host_empty   (host_empty),
    .src_level    (src_level),
    .snk_level    (snk_level)
`ifdef SAMPLE_RESPONDER_STATS_EN
    ,
    .src_xfers    (src_xfers),
    .snk_xfers    (snk_xfers),
    .stall_cycles (stall_cycles)
`endif
  );

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic host_push(input logic [0:DW-1] d);
    host_wr_en   = 1'b1;
    host_wr_data = d;
    @(negedge clk);
    host_wr_en   = 1'b0;
  endtask

  task automatic host_pop(output logic [0:DW-1] d);
    d          = host_rd_data;
    host_rd_en = 1'b1;
    @(negedge clk);
    host_rd_en = 1'b0;
  endtask

  task automatic src_hs(output logic [0:DW-1] d, output bit got);
    src_req = 1'b1;
    got     = 1'b0;
    for (int k = 0; k < 8; k++) begin
      @(negedge clk);
      if (src_ack) begin got = 1'b1; break; end
    end
    d       = src_data;
    src_req = 1'b0;
    @(negedge clk);
    chk("src_ack_fall", src_ack, 0);
  endtask

  task automatic snk_hs(input logic [0:DW-1] d, output bit got);
    snk_req  = 1'b1;
    snk_data = d;
    got      = 1'b0;
    for (int k = 0; k < 8; k++) begin
      @(negedge clk);
      if (snk_ack) begin got = 1'b1; break; end
    end
    snk_req = 1'b0;
    @(negedge clk);
    chk("snk_ack_fall", snk_ack, 0);
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog timeout");
    $fatal(1);
  end

  initial begin
    logic [0:DW-1] d, e;
    bit            got;
    int            hi;

    rst = 1'b1; src_req = 0; snk_req = 0; host_wr_en = 0; host_rd_en = 0;
    snk_data = '0; host_wr_data = '0;
    @(negedge clk); @(negedge clk);
    chk("rst_src_ack", src_ack, 0);
    chk("rst_snk_ack", snk_ack, 0);
    chk("rst_src_data", src_data, 0);
    chk("rst_src_level", src_level, 0);
    chk("rst_snk_level", snk_level, 0);
    chk("rst_host_full", host_full, 0);
    chk("rst_host_empty", host_empty, 1);
    rst = 1'b0;
    @(negedge clk);

    // Two preloaded samples served in order
    host_push(32'h00010002);
    host_push(32'h00030004);
    chk("t1_level2", src_level, 2);
    src_req = 1'b1;
    @(negedge clk);
    chk("t1_ack_1cyc", src_ack, 1);
    chk("t1_data0", src_data, 32'h00010002);
    chk("t1_level1", src_level, 1);
    src_req = 1'b0;
    @(negedge clk);
    chk("t1_ack_drop", src_ack, 0);
    src_hs(d, got);
    chk("t1_got1", got, 1);
    chk("t1_data1", d, 32'h00030004);
    chk("t1_level0", src_level, 0);

    // Request against empty FIFO stalls until the host writes
    src_req = 1'b1;
    hi = 0;
    repeat (20) begin
      @(negedge clk);
      if (src_ack) hi++;
    end
    chk("stall_ack_low", hi, 0);
    host_wr_en = 1'b1; host_wr_data = 32'hDEADBEEF;
    @(negedge clk);
    host_wr_en = 1'b0;
    chk("stall_wr_plus1", src_ack, 0);
    @(negedge clk);
    chk("stall_wr_plus2", src_ack, 1);
    chk("stall_data", src_data, 32'hDEADBEEF);
    src_req = 1'b0;
    @(negedge clk);

    // Sink fills to DEPTH, the ninth offer stalls until one host read
    for (int i = 0; i < DEPTH; i++) begin
      snk_hs(i, got);
      chk("snk_fill_ack", got, 1);
    end
    chk("snk_level_full", snk_level, DEPTH);
    snk_req = 1'b1; snk_data = 32'd8;
    hi = 0;
    repeat (6) begin
      @(negedge clk);
      if (snk_ack) hi++;
    end
    chk("snk_full_stall", hi, 0);
    chk("snk_head0", host_rd_data, 0);
    host_rd_en = 1'b1;
    @(negedge clk);
    host_rd_en = 1'b0;
    got = 1'b0;
    for (int k = 0; k < 4; k++) begin
      @(negedge clk);
      if (snk_ack) begin got = 1'b1; break; end
    end
    chk("snk_ninth_ack", got, 1);
    chk("snk_ninth_level", snk_level, DEPTH);
    snk_req = 1'b0;
    @(negedge clk);
    for (int i = 1; i <= 8; i++) begin
      host_pop(d);
      chk("snk_drain", d, i);
    end
    chk("snk_drained_empty", host_empty, 1);

    // Same-cycle host push and FSM pop at level 3
    host_push(32'hA); host_push(32'hB); host_push(32'hC);
    chk("sim_level3", src_level, 3);
    host_wr_en = 1'b1; host_wr_data = 32'hD; src_req = 1'b1;
    @(negedge clk);
    host_wr_en = 1'b0;
    chk("sim_level_kept", src_level, 3);
    chk("sim_ack", src_ack, 1);
    chk("sim_data_a", src_data, 32'hA);
    src_req = 1'b0;
    @(negedge clk);
    for (int i = 0; i < 3; i++) begin
      src_hs(d, got);
      chk("sim_got", got, 1);
      chk("sim_order", d, 32'hB + i);
    end

    // Random mix against queue model
    for (int it = 0; it < 80; it++) begin
      case ($urandom_range(0, 3))
        0: if (q_src.size() < DEPTH) begin
             d = $urandom;
             host_push(d);
             q_src.push_back(d);
           end else chk("rnd_host_full", host_full, 1);
        1: if (q_src.size() > 0) begin
             src_hs(d, got);
             e = q_src.pop_front();
             chk("rnd_src_got", got, 1);
             chk("rnd_src_data", d, e);
           end else begin
             src_req = 1'b1;
             hi = 0;
             repeat (3) begin
               @(negedge clk);
               if (src_ack) hi++;
             end
             src_req = 1'b0;
             @(negedge clk);
             chk("rnd_src_stall", hi, 0);
           end
        2: if (q_snk.size() < DEPTH) begin
             d = $urandom;
             snk_hs(d, got);
             chk("rnd_snk_got", got, 1);
             q_snk.push_back(d);
           end else chk("rnd_snk_full", snk_level, DEPTH);
        default: if (q_snk.size() > 0) begin
             e = q_snk.pop_front();
             host_pop(d);
             chk("rnd_host_rd", d, e);
           end else chk("rnd_host_empty", host_empty, 1);
      endcase
      chk("rnd_src_level", src_level, q_src.size());
      chk("rnd_snk_level", snk_level, q_snk.size());
    end

    // Async reset mid-handshake
    q_src.delete(); q_snk.delete();
    host_push(32'h12345678);
    src_req = 1'b1;
    @(negedge clk);
    chk("mid_ack_before", src_ack, 1);
    #2 rst = 1'b1;
    #1;
    chk("mid_ack_async", src_ack, 0);
    chk("mid_data", src_data, 0);
    chk("mid_src_level", src_level, 0);
    chk("mid_snk_level", snk_level, 0);
    chk("mid_host_empty", host_empty, 1);
    chk("mid_host_full", host_full, 0);
    src_req = 1'b0;
    @(negedge clk);
    rst = 1'b0;

    // Five blocked cycles then four source transfers
    src_req = 1'b1;
    repeat (4) @(negedge clk);
    host_wr_en = 1'b1; host_wr_data = 32'h1;
    @(negedge clk);
    host_wr_en = 1'b0;
    @(negedge clk);
    chk("st_ack1", src_ack, 1);
    src_req = 1'b0;
    @(negedge clk);
    host_push(32'h2); host_push(32'h3); host_push(32'h4);
    for (int i = 0; i < 3; i++) begin
      src_hs(d, got);
      chk("st_data", d, 32'h2 + i);
    end
    chk("st_level0", src_level, 0);
`ifdef SAMPLE_RESPONDER_STATS_EN
    chk("st_src_xfers", src_xfers, 4);
    chk("st_snk_xfers", snk_xfers, 0);
    chk("st_stall_cycles", stall_cycles, 5);
`endif

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/sample_responder.md
Name: sample_responder

Overview:
- Responder end of the four-phase req/ack sample protocol used by the filter wrapper.
- Serves input samples to an initiator's input request port and absorbs result samples from its output request port.
- Host side loads stimulus into a source FIFO and drains results from a sink FIFO.
- Replaces ad-hoc testbench handshake code; also usable on-chip as a sample buffer.

Parameters:
- DDWIDTH, 32, sample width on both channels (packed pair of DWIDTH=16 words).
- DEPTH, 8, entries per FIFO; power of two, at least 2.
- AWIDTH, 3, log2(DEPTH).

Ports:
- clk  in  1  rising-edge clock
- rst  in  1  asynchronous, active-high reset
- src_req  in  1  initiator requests an input sample
- src_ack  out  1  responder: src_data valid
- src_data  out  [0:DDWIDTH-1]  sample to initiator
- snk_req  in  1  initiator offers a result
- snk_ack  out  1  responder: result taken
- snk_data  in  [0:DDWIDTH-1]  result from initiator
- host_wr_en  in  1  push host_wr_data into source FIFO
- host_wr_data  in  [0:DDWIDTH-1]  stimulus word
- host_full  out  1  source FIFO full
- host_rd_en  in  1  pop sink FIFO
- host_rd_data  out  [0:DDWIDTH-1]  sink FIFO head (show-ahead)
- host_empty  out  1  sink FIFO empty
- src_level  out  [0:AWIDTH]  source FIFO occupancy
- snk_level  out  [0:AWIDTH]  sink FIFO occupancy

Behaviour:
- Reset (async, rst high): src_ack=0, snk_ack=0, src_data=0, both FIFOs emptied, levels=0, host_full=0, host_empty=1, FSMs to IDLE. Reset mid-handshake drops ack immediately; the initiator sees no completion.
- Source FSM, states IDLE and ACKED:
  - IDLE, src_req=1 and source FIFO non-empty: register FIFO head into src_data, pop, src_ack<=1, go to ACKED. src_ack rises 1 cycle after src_req is sampled high.
  - IDLE, src_req=1 and FIFO empty: stay in IDLE with ack low; the request stalls indefinitely.
  - ACKED: src_data held stable. When src_req=0: src_ack<=0, go to IDLE. A new request is served no earlier than 1 cycle after ack falls.
- Sink FSM, states IDLE and ACKED:
  - IDLE, snk_req=1 and sink FIFO not full: capture snk_data in that same cycle, push, snk_ack<=1, go to ACKED.
  - Sink FIFO full: stall with ack low.
  - ACKED: wait for snk_req=0, then snk_ack<=0, go to IDLE.
- FIFOs: synchronous, pointer-based, AWIDTH+1 bit occupancy.
  - Simultaneous push and pop on one FIFO: level unchanged, both take effect. Pop while full is allowed.
  - Push while full is ignored; host_full must be honoured.
  - Pop while empty is ignored; host_rd_data is unchanged.
  - Pointers wrap modulo DEPTH.
- The two channels are fully independent; simultaneous events on both proceed in the same cycle.
- No arithmetic on sample data; bit 0 is the MSB throughout.

Optional Feature:
- Macro: SAMPLE_RESPONDER_STATS_EN.
- When defined, adds three 32-bit wrapping output counters, all reset to 0:
  - src_xfers: incremented when src_ack rises.
  - snk_xfers: incremented when snk_ack rises.
  - stall_cycles: incremented in every cycle where a request is high in IDLE but blocked by empty or full.
- When undefined, these ports and registers are absent; all other behaviour is identical.

Decomposition:
- Shared package: FSM state constants ST_IDLE=0 and ST_ACKED=1, and the default DDWIDTH/DEPTH constants.
- One sub-module, sample_fifo (parameters DDWIDTH and AWIDTH), instantiated twice: source and sink.
- Handshake FSMs live in the top level.

Test Plan:
- Preload 0x00010002, 0x00030004; hold src_req high until ack, then drop -> src_ack rises 1 cycle after req; src_data=0x00010002, then 0x00030004 on the next handshake; src_level goes 2 -> 1 -> 0.
- src_req high with empty FIFO for 20 cycles, then host writes 0xDEADBEEF -> ack stays low throughout, rises 2 cycles after the write with src_data=0xDEADBEEF.
- Initiator offers 9 results 0..8 with DEPTH=8 and no host reads -> 8 acks; the 9th request stalls; one host_rd_en returns 0 and the 9th is then accepted with value 8.
- Assert rst while src_ack=1 -> src_ack=0 with no clock edge needed; FIFOs empty; src_data=0.
- Host pushes and FSM pops the source FIFO in the same cycle at level 3 -> level stays 3 and data order is preserved.
- With SAMPLE_RESPONDER_STATS_EN: 4 source transfers and 5 stall cycles -> src_xfers=4, stall_cycles=5.
